// File: rtl/conv_pkg.sv
// Shared types and kernel tables for the 3x3 stream convolution engine.
// Kernel rows/columns are indexed [mode][row][col]; all kernels are symmetric.
package conv_pkg;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        EDGE    = 2'd1,
        BLUR    = 2'd2,
        SHARPEN = 2'd3
    } conv_mode_e;

    // Accumulator is PIX_W + ACC_GUARD bits signed: covers 16*max (blur) and -8*max (edge).
    localparam int ACC_GUARD  = 5;
    localparam int BLUR_SHIFT = 4;

    localparam int KERNEL [4][3][3] = '{
        '{'{ 0,  0,  0}, '{ 0,  1,  0}, '{ 0,  0,  0}},
        '{'{-1, -1, -1}, '{-1,  8, -1}, '{-1, -1, -1}},
        '{'{ 1,  2,  1}, '{ 2,  4,  2}, '{ 1,  2,  1}},
        '{'{ 0, -1,  0}, '{-1,  5, -1}, '{ 0, -1,  0}}
    };

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage. rdata shows the word stored before this cycle's write,
// so a read and a write at the same address in one cycle return the previous line.
module conv_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 30,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// 3x3 convolution on a valid/ready pixel stream: window shift, MAC, saturate (3 stages).
// Define CONV_THRESHOLD_EN to add a threshold port that binarises EDGE output.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int PIX_W = 10,
    parameter int CH    = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          mode,
`ifdef CONV_THRESHOLD_EN
    input  logic [PIX_W-1:0]    threshold,
`endif
    input  logic [CH*PIX_W-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic [CH*PIX_W-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready
);

    localparam int N     = CH * PIX_W;
    localparam int ACC_W = PIX_W + ACC_GUARD;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic signed [ACC_W-1:0] MAX_ACC = ACC_W'((1 << PIX_W) - 1);
    localparam logic [PIX_W-1:0]        MAX_PIX = '1;

    logic             en;
    logic             accept;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    conv_mode_e       mode_q, mode1_q, mode2_q, mode_sel;
    logic [N-1:0]     lb0_rd, lb1_rd;
    logic [N-1:0]     win_q [3][3];
    logic             v1_q, v2_q, border1_q, border2_q;
    logic [N-1:0]     sat_d;

    assign en      = !y_valid || y_ready;
    assign x_ready = en;
    assign accept  = x_valid && en;

    // The frame's kernel is latched with its first pixel and held until the next frame.
    assign mode_sel = (col_q == '0 && row_q == '0) ? conv_mode_e'(mode) : mode_q;

`ifdef CONV_THRESHOLD_EN
    logic signed [ACC_W-1:0] thr_acc;
    assign thr_acc = $signed({{ACC_GUARD{1'b0}}, threshold});
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= PASS;
        end else if (accept) begin
            mode_q <= mode_sel;
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // lb0 holds the previous line, lb1 the line before; lb1 is fed from lb0's old word.
    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(N), .AW(COL_W)) u_lb0 (
        .clk   (clk),
        .en    (accept),
        .addr  (col_q),
        .wdata (x_data),
        .rdata (lb0_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(N), .AW(COL_W)) u_lb1 (
        .clk   (clk),
        .en    (accept),
        .addr  (col_q),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Stage 1: window [row][col], row 0 oldest line, col 2 newest column.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            v1_q      <= 1'b0;
            border1_q <= 1'b0;
            mode1_q   <= PASS;
        end else if (en) begin
            v1_q <= accept;
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb1_rd;
                win_q[1][2] <= lb0_rd;
                win_q[2][2] <= x_data;
                border1_q   <= (row_q < ROW_W'(2)) || (col_q < COL_W'(2));
                mode1_q     <= mode_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q      <= 1'b0;
            border2_q <= 1'b0;
            mode2_q   <= PASS;
            y_valid   <= 1'b0;
            y_data    <= '0;
        end else if (en) begin
            v2_q      <= v1_q;
            border2_q <= border1_q;
            mode2_q   <= mode1_q;
            y_valid   <= v2_q;
            y_data    <= sat_d;
        end
    end

    for (genvar ch = 0; ch < CH; ch++) begin : g_ch
        logic signed [ACC_W-1:0] acc_d, acc2_q, mag;
        logic [PIX_W-1:0]        res;

        always_comb begin
            acc_d = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    acc_d = acc_d + ACC_W'(KERNEL[mode1_q][i][j]
                                           * int'(win_q[i][j][ch*PIX_W +: PIX_W]));
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc2_q <= '0;
            end else if (en) begin
                acc2_q <= acc_d;
            end
        end

        always_comb begin
            mag = acc2_q[ACC_W-1] ? -acc2_q : acc2_q;
            res = '0;
            unique case (mode2_q)
                PASS: res = acc2_q[PIX_W-1:0];
                EDGE: begin
`ifdef CONV_THRESHOLD_EN
                    res = (mag >= thr_acc) ? MAX_PIX : '0;
`else
                    res = (mag > MAX_ACC) ? MAX_PIX : mag[PIX_W-1:0];
`endif
                end
                BLUR: res = PIX_W'(acc2_q >>> BLUR_SHIFT);
                SHARPEN: begin
                    if (acc2_q[ACC_W-1]) begin
                        res = '0;
                    end else if (acc2_q > MAX_ACC) begin
                        res = MAX_PIX;
                    end else begin
                        res = acc2_q[PIX_W-1:0];
                    end
                end
                default: res = '0;
            endcase
            // Window straddles a line or frame edge here; stale buffer data is masked.
            if (border2_q) begin
                res = '0;
            end
        end

        assign sat_d[ch*PIX_W +: PIX_W] = res;
    end

endmodule
